// File: rtl/sbox_array_pipe.sv
// rtl/sbox_array_pipe.sv - multi-lane pipelined AES S-box / inverse S-box engine
// Composite-field GF((2^4)^2) inverter; tower basis derived at elaboration from the field polynomials.
module sbox_array_pipe #(
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [8*NUM_LANES-1:0] in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_LANES-1:0] out_data,
  output logic                   out_inv,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, s;
    p = 4'h0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = r ^ cols[8*i +: 8];
    end
    return r;
  endfunction

  // Smallest lambda making x^2 + x + lambda irreducible over GF(2^4).
  function automatic logic [3:0] pick_lambda();
    logic [3:0] lam;
    logic       found, has_root;
    lam   = 4'h0;
    found = 1'b0;
    for (int c = 1; c < 16; c++) begin
      has_root = 1'b0;
      for (int t = 0; t < 16; t++) begin
        if ((gf4_mul(t[3:0], t[3:0]) ^ t[3:0]) == c[3:0]) has_root = 1'b1;
      end
      if (!found && !has_root) begin
        lam   = c[3:0];
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  // Column j = AES-basis image of tower bit j: low nibble W^j, high nibble X*W^j.
  function automatic logic [63:0] tower_cols();
    logic [7:0]  w, x, lam_a, p;
    logic [3:0]  lam;
    logic        fw, fx;
    logic [63:0] cols;
    w  = 8'h00;
    fw = 1'b0;
    for (int c = 2; c < 256; c++) begin
      p = gf8_mul(c[7:0], c[7:0]);
      if (!fw && ((gf8_mul(p, p) ^ c[7:0]) == 8'h01)) begin
        w  = c[7:0];
        fw = 1'b1;
      end
    end
    lam   = pick_lambda();
    lam_a = 8'h00;
    p     = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (lam[i]) lam_a = lam_a ^ p;
      p = gf8_mul(p, w);
    end
    x  = 8'h00;
    fx = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (!fx && ((gf8_mul(c[7:0], c[7:0]) ^ c[7:0]) == lam_a)) begin
        x  = c[7:0];
        fx = 1'b1;
      end
    end
    cols = '0;
    p    = 8'h01;
    for (int j = 0; j < 4; j++) begin
      cols[8*j +: 8]     = p;
      cols[8*(j+4) +: 8] = gf8_mul(x, p);
      p = gf8_mul(p, w);
    end
    return cols;
  endfunction

  function automatic logic [63:0] iso_cols(input logic [63:0] tc);
    logic [63:0] iso;
    iso = '0;
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 256; t++) begin
        if (lin_map(tc, t[7:0]) == (8'h01 << i)) iso[8*i +: 8] = t[7:0];
      end
    end
    return iso;
  endfunction

  localparam logic [3:0]  LAMBDA   = pick_lambda();
  localparam logic [63:0] TO_AES   = tower_cols();
  localparam logic [63:0] TO_TOWER = iso_cols(TO_AES);

  function automatic logic [3:0] gf4_inv(input logic [3:0] d);
    logic [3:0] d2, d3, d6, d12;
    d2  = gf4_mul(d, d);
    d3  = gf4_mul(d2, d);
    d6  = gf4_mul(d3, d3);
    d12 = gf4_mul(d6, d6);
    return gf4_mul(d12, d2);
  endfunction

  function automatic logic [11:0] seg1(input logic [7:0] x, input logic inv);
    logic [7:0] a, t;
    a = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
    t = lin_map(TO_TOWER, a);
    return {t, gf4_mul(gf4_mul(t[7:4], t[7:4]), LAMBDA) ^ gf4_mul(t[7:4], t[3:0])
               ^ gf4_mul(t[3:0], t[3:0])};
  endfunction

  function automatic logic [11:0] seg2(input logic [11:0] v);
    return {v[11:4], gf4_inv(v[3:0])};
  endfunction

  function automatic logic [7:0] seg3(input logic [11:0] v, input logic inv);
    logic [7:0] y;
    y = lin_map(TO_AES, {gf4_mul(v[11:8], v[3:0]), gf4_mul(v[11:8] ^ v[7:4], v[3:0])});
    return inv ? y : (y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                      ^ {y[3:0], y[7:4]} ^ 8'h63);
  endfunction

  logic [PIPE_STAGES-1:0]   v_q, v_d, adv, ld, inv_q, inv_src;
  logic [TAG_W-1:0]         tag_q [PIPE_STAGES];
  logic [TAG_W-1:0]         tag_src [PIPE_STAGES];
  logic                     nxt_free, seg3_inv;
  logic [12*NUM_LANES-1:0]  seg1_w, seg2_in, seg2_w, seg3_in;
  logic [8*NUM_LANES-1:0]   seg3_w, out_data_q;

  // A stage is free when empty or emptying this cycle, so bubbles collapse under a stalled output.
  always_comb begin
    nxt_free = out_ready;
    adv      = '0;
    ld       = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      adv[k]   = v_q[k] & nxt_free;
      nxt_free = !v_q[k] | adv[k];
    end
    in_ready = nxt_free;
    ld[0]    = in_valid & nxt_free;
    for (int k = 1; k < PIPE_STAGES; k++) ld[k] = adv[k-1];
    v_d = ld | (v_q & ~adv);
  end

  always_comb begin
    inv_src    = '0;
    inv_src[0] = in_inv;
    tag_src[0] = in_tag;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      inv_src[k] = inv_q[k-1];
      tag_src[k] = tag_q[k-1];
    end
  end

  always_comb begin
    seg1_w = '0;
    for (int i = 0; i < NUM_LANES; i++) seg1_w[12*i +: 12] = seg1(in_data[8*i +: 8], in_inv);
  end

  always_comb begin
    seg2_w = '0;
    for (int i = 0; i < NUM_LANES; i++) seg2_w[12*i +: 12] = seg2(seg2_in[12*i +: 12]);
  end

  always_comb begin
    seg3_w = '0;
    for (int i = 0; i < NUM_LANES; i++) seg3_w[8*i +: 8] = seg3(seg3_in[12*i +: 12], seg3_inv);
  end

  generate
    if (PIPE_STAGES == 1) begin : g_p1
      assign seg2_in  = seg1_w;
      assign seg3_in  = seg2_w;
      assign seg3_inv = in_inv;
    end else begin : g_pn
      logic [12*NUM_LANES-1:0] mid0_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mid0_q <= '0;
        else if (ld[0]) mid0_q <= seg1_w;
      end
      assign seg2_in = mid0_q;
      if (PIPE_STAGES == 2) begin : g_p2
        assign seg3_in  = seg2_w;
        assign seg3_inv = inv_q[0];
      end else begin : g_p3
        logic [12*NUM_LANES-1:0] mid1_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)     mid1_q <= '0;
          else if (ld[1]) mid1_q <= seg2_w;
        end
        assign seg3_in  = mid1_q;
        assign seg3_inv = inv_q[1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= '0;
      inv_q      <= '0;
      out_data_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) tag_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (ld[k]) begin
          inv_q[k] <= inv_src[k];
          tag_q[k] <= tag_src[k];
        end
      end
      if (ld[PIPE_STAGES-1]) out_data_q <= seg3_w;
    end
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign out_data  = out_data_q;
  assign out_inv   = inv_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_sbox_array_pipe.sv
// tb/tb_sbox_array_pipe.sv - scoreboard bench for sbox_array_pipe
// Reference S-box built from brute-force GF(2^8) inverse and the bitwise affine form.
module tb_sbox_array_pipe;
  localparam int NL = 4;
  localparam int PS = 2;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
  logic [8*NL-1:0] in_data, out_data;
  logic [TW-1:0]   in_tag, out_tag;

  always #5 clk = ~clk;

  sbox_array_pipe #(.NUM_LANES(NL), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .out_tag(out_tag), .busy(busy)
  );

  typedef struct { logic [31:0] data; logic inv; logic [3:0] tag; } beat_t;
  typedef struct { logic inv; logic [31:0] din; logic [31:0] dout; } vec_t;

  beat_t       sb_q[$];
  logic [31:0] out_log[$];
  logic [31:0] stim_d[$];
  logic        stim_i[$];
  logic [7:0]  sbox[256];
  logic [7:0]  isbox[256];
  int          n_cmp = 0, n_err = 0, last_acc = 0, last_cyc = 0;
  logic        hold_flag = 1'b0;

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= s;
      s = (s << 1) ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_affine(input logic [7:0] b);
    logic [7:0] r, c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int i = 0; i < NL; i++) r[8*i +: 8] = inv ? isbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] pat(input int j);
    logic [31:0] r;
    for (int i = 0; i < NL; i++) r[8*i +: 8] = 8'((j + 64*i) & 255);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic inv, input logic [31:0] d,
                      input logic [3:0] tg, input logic ordy, output logic acc);
    beat_t b;
    @(negedge clk);
    in_valid = iv; in_inv = inv; in_data = d; in_tag = tg; out_ready = ordy;
    #1;
    check("busy_vs_occupancy", busy, 64'(sb_q.size() != 0));
    if (hold_flag) check("valid_held_under_stall", out_valid, 1);
    if (out_valid) begin
      check("out_has_expected", 64'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        check("out_data", out_data, sb_q[0].data);
        check("out_inv", out_inv, sb_q[0].inv);
        check("out_tag", out_tag, sb_q[0].tag);
        if (out_ready) begin
          void'(sb_q.pop_front());
          out_log.push_back(out_data);
        end
      end
    end
    hold_flag = out_valid && !out_ready;
    acc = iv && in_ready;
    if (acc) begin
      b.data = model(d, inv); b.inv = inv; b.tag = tg;
      sb_q.push_back(b);
    end
  endtask

  task automatic drain(input int budget);
    int   n = 0;
    logic a;
    while (sb_q.size() != 0 && n < budget) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, a);
      n++;
    end
    check("drain_done", sb_q.size(), 0);
  endtask

  task automatic run_stream(input int pv, input int pr, input int budget);
    int   idx = 0, cyc = 0;
    logic acc, iv;
    while (idx < stim_d.size() && cyc < budget) begin
      iv = ($urandom_range(0, 99) < pv);
      step(iv, iv ? stim_i[idx] : 1'($urandom_range(0, 1)), iv ? stim_d[idx] : 32'($urandom),
           4'(idx), ($urandom_range(0, 99) < pr), acc);
      if (acc) idx++;
      cyc++;
    end
    last_acc = idx;
    last_cyc = cyc;
  endtask

  task automatic single_vec(input vec_t v, input string tagname);
    logic acc;
    step(1'b1, v.inv, v.din, 4'h5, 1'b1, acc);
    check({tagname, "_accept"}, acc, 1);
    for (int s = 1; s < PS; s++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, acc);
      check({tagname, "_not_early"}, out_valid, 0);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b1, acc);
    check({tagname, "_latency_valid"}, out_valid, 1);
    check({tagname, "_data"}, out_data, v.dout);
  endtask

  vec_t        vecs[4];
  logic [31:0] fwd_out[$];

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv8 = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) iv8 = 8'(y);
      sbox[x] = m_affine(iv8);
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    vecs[0] = '{1'b0, 32'hFF530100, 32'h16ED7C63};
    vecs[1] = '{1'b1, 32'h16ED7C63, 32'hFF530100};
    vecs[2] = '{1'b0, 32'h40302010, 32'h0904B7CA};
    vecs[3] = '{1'b1, 32'h0904B7CA, 32'h40302010};

    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_inv", out_inv, 0);
    check("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) single_vec(vecs[i], "vec");

    // Exhaustive round trip: each lane sees all 256 values forward, then inverse.
    stim_d.delete(); stim_i.delete(); out_log.delete();
    for (int j = 0; j < 256; j++) begin stim_d.push_back(pat(j)); stim_i.push_back(1'b0); end
    run_stream(100, 100, 2000);
    check("rt_fwd_accepted", last_acc, 256);
    drain(50);
    fwd_out = out_log;
    check("rt_fwd_count", fwd_out.size(), 256);
    stim_d = fwd_out; stim_i.delete(); out_log.delete();
    for (int j = 0; j < stim_d.size(); j++) stim_i.push_back(1'b1);
    run_stream(100, 100, 2000);
    drain(50);
    check("rt_inv_count", out_log.size(), 256);
    for (int j = 0; j < out_log.size(); j++) check("roundtrip_identity", out_log[j], pat(j));

    // Alternating mode every beat, tags 0..15, no bubbles.
    stim_d.delete(); stim_i.delete();
    for (int j = 0; j < 16; j++) begin stim_d.push_back($urandom); stim_i.push_back(j[0]); end
    run_stream(100, 100, 100);
    check("alt_cycles_no_bubble", last_cyc, 16);
    check("alt_in_flight", sb_q.size(), PS);
    drain(50);

    // Output stalled for 10 cycles with input offered every cycle.
    stim_d.delete(); stim_i.delete();
    for (int j = 0; j < 10; j++) begin stim_d.push_back($urandom); stim_i.push_back(1'($urandom_range(0, 1))); end
    out_log.delete();
    run_stream(100, 0, 10);
    check("stall_accepted", last_acc, PS);
    check("stall_in_ready_low", in_ready, 0);
    check("stall_busy", busy, 1);
    drain(50);
    check("stall_drained_count", out_log.size(), PS);

    // Random valid/ready at 50%.
    stim_d.delete(); stim_i.delete();
    for (int j = 0; j < 10000; j++) begin stim_d.push_back($urandom); stim_i.push_back(1'($urandom_range(0, 1))); end
    run_stream(50, 50, 60000);
    check("rand_accepted", last_acc, 10000);
    drain(200);

    // Reset with the pipeline full.
    stim_d.delete(); stim_i.delete();
    for (int j = 0; j < PS; j++) begin stim_d.push_back($urandom); stim_i.push_back(1'b0); end
    run_stream(100, 0, 4 * PS);
    check("prerst_full", last_acc, PS);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    sb_q.delete();
    hold_flag = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    single_vec(vecs[2], "post_rst");
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
